casex_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one casex-decoded downstream resource between four requesters. It selects a winner with a rotated priority decoder, holds the grant until the owner finishes, drops its request or exceeds a hold limit, and inserts one idle gap between owners. It drives the 3-bit `state` code that the downstream casex decoder consumes, alongside a one-hot grant vector.

---
 rtl/casex_rr_arbiter.sv | 141 ++++++++++++++
 tb/tb_casex_rr_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/casex_rr_arbiter.sv
// casex_rr_arbiter: round-robin sharing of one casex-decoded resource among four requesters.
// Latency: grant/state are valid one cycle after req is sampled; exactly one GAP cycle between owners.
// Backpressure: none; the owner keeps the grant until done, request drop, or MAX_HOLD cycles.
module casex_rr_arbiter #(
   parameter int MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] grant,
   output logic [2:0] state,
   output logic       busy,
   output logic       timeout
);

   localparam logic [2:0] HOLD_LAST = 3'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_GAP   = 2'd2
   } fsm_t;

   fsm_t       r_fsm;
   fsm_t       w_fsm_nxt;
   logic [1:0] r_owner;
   logic [1:0] w_owner_nxt;
   logic [1:0] r_last;
   logic [1:0] w_last_nxt;
   logic [2:0] r_cnt;
   logic [2:0] w_cnt_nxt;
   logic [3:0] r_grant;
   logic [3:0] w_grant_nxt;
   logic [2:0] r_state;
   logic [2:0] w_state_nxt;
   logic       r_timeout;
   logic       w_timeout_nxt;

   logic [7:0] w_req2;
   logic [2:0] w_start;
   logic [3:0] w_rot;
   logic [1:0] w_off;
   logic [1:0] w_win;
   logic       w_any;
   logic       w_release;
   logic       w_limit;

   // Rotate req so that index last+1 sits at bit 0 (highest priority)
   // and last sits at bit 3 (lowest priority).
   assign w_req2  = {req, req};
   assign w_start = {1'b0, r_last + 2'd1};
   assign w_rot   = w_req2[w_start +: 4];
   assign w_any   = |req;

   // Priority decode of the rotated request vector; the offset maps back to a requester index.
   always_comb begin
      w_off = 2'd0;
      casez (w_rot)
         4'b???1: w_off = 2'd0;
         4'b??10: w_off = 2'd1;
         4'b?100: w_off = 2'd2;
         4'b1000: w_off = 2'd3;
         default: w_off = 2'd0;
      endcase
   end

   // 2-bit addition wraps modulo 4, undoing the rotation.
   assign w_win = r_last + 2'd1 + w_off;

   // Owner release has priority over the hold limit, so done and timeout never coincide.
   assign w_release = done | ~req[r_owner];
   assign w_limit   = (r_cnt == HOLD_LAST);

   // Next-state and registered-output computation for IDLE / GRANT / GAP.
   always_comb begin
      w_fsm_nxt     = r_fsm;
      w_owner_nxt   = r_owner;
      w_last_nxt    = r_last;
      w_cnt_nxt     = r_cnt;
      w_grant_nxt   = r_grant;
      w_state_nxt   = r_state;
      w_timeout_nxt = 1'b0;
      case (r_fsm)
         S_GRANT: begin
            if (w_release || w_limit) begin
               w_fsm_nxt     = S_GAP;
               w_last_nxt    = r_owner;
               w_grant_nxt   = 4'b0000;
               w_state_nxt   = 3'b010;
               w_cnt_nxt     = 3'd0;
               w_timeout_nxt = ~w_release;
            end else begin
               w_cnt_nxt = r_cnt + 3'd1;
            end
         end
         default: begin
            // IDLE and GAP arbitrate the same way; GAP only ever lasts one cycle.
            if (w_any) begin
               w_fsm_nxt   = S_GRANT;
               w_owner_nxt = w_win;
               w_grant_nxt = 4'b0001 << w_win;
               w_state_nxt = {1'b1, w_win};
               w_cnt_nxt   = 3'd0;
            end else begin
               w_fsm_nxt   = S_IDLE;
               w_grant_nxt = 4'b0000;
               w_state_nxt = 3'b000;
               w_cnt_nxt   = 3'd0;
            end
         end
      endcase
   end

   // State and output registers; reset takes effect immediately, even mid-grant.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_fsm     <= S_IDLE;
         r_owner   <= 2'd0;
         r_last    <= 2'd3;
         r_cnt     <= 3'd0;
         r_grant   <= 4'b0000;
         r_state   <= 3'b000;
         r_timeout <= 1'b0;
      end else begin
         r_fsm     <= w_fsm_nxt;
         r_owner   <= w_owner_nxt;
         r_last    <= w_last_nxt;
         r_cnt     <= w_cnt_nxt;
         r_grant   <= w_grant_nxt;
         r_state   <= w_state_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   assign grant   = r_grant;
   assign state   = r_state;
   assign busy    = r_state[2];
   assign timeout = r_timeout;

endmodule

// File: tb/tb_casex_rr_arbiter.sv
// tb_casex_rr_arbiter: directed and random stimulus against a cycle-level behavioural model.
// Latency: outputs compared once per cycle at the falling edge.
// Backpressure: not applicable; inputs are driven freely.
module tb_casex_rr_arbiter;

   localparam int MAX_HOLD = 4;

   logic       clk = 1'b0;
   logic       rstn;
   logic [3:0] req;
   logic       done;
   logic [3:0] grant;
   logic [2:0] state;
   logic       busy;
   logic       timeout;

   int total = 0;
   int bad   = 0;

   // Behavioural model: owner index (-1 = none), cycles owned so far, pointer, gap flag, timeout flag.
   int m_owner;
   int m_held;
   int m_last;
   bit m_gap;
   bit m_to;

   logic [3:0] prev_g;
   logic [3:0] order_q[$];
   logic [3:0] r_rand;
   logic       d_rand;

   always #5 clk = ~clk;

   casex_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .req     (req),
      .done    (done),
      .grant   (grant),
      .state   (state),
      .busy    (busy),
      .timeout (timeout)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // First active requester scanning upward from the one after the last owner.
   function automatic int pick(input logic [3:0] r);
      for (int k = 1; k <= 4; k++) begin
         int idx;
         idx = (m_last + k) % 4;
         if (r[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_held  = 0;
      m_last  = 3;
      m_gap   = 1'b0;
      m_to    = 1'b0;
   endtask

   task automatic model_step(input logic [3:0] r, input logic d);
      if (m_owner >= 0) begin
         if (d || !r[m_owner]) begin
            m_last = m_owner; m_owner = -1; m_gap = 1'b1; m_to = 1'b0;
         end else if (m_held == MAX_HOLD) begin
            m_last = m_owner; m_owner = -1; m_gap = 1'b1; m_to = 1'b1;
         end else begin
            m_held++;
         end
      end else begin
         int w;
         m_gap = 1'b0;
         m_to  = 1'b0;
         w = pick(r);
         if (w >= 0) begin
            m_owner = w;
            m_held  = 1;
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [3:0] eg;
      logic [2:0] es;
      eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
      es = (m_owner >= 0) ? 3'(4 + m_owner) : (m_gap ? 3'b010 : 3'b000);
      check({tag, ".grant"},   32'(grant),   32'(eg));
      check({tag, ".state"},   32'(state),   32'(es));
      check({tag, ".busy"},    32'(busy),    32'(m_owner >= 0));
      check({tag, ".timeout"}, 32'(timeout), 32'(m_to));
   endtask

   // Called at a falling edge: drive inputs, predict, then compare at the next falling edge.
   task automatic cycle(input string tag, input logic [3:0] r, input logic d);
      req  = r;
      done = d;
      model_step(r, d);
      @(negedge clk);
      check_outputs(tag);
   endtask

   task automatic apply_reset();
      rstn = 1'b0;
      req  = 4'b0000;
      done = 1'b0;
      model_reset();
      #1;
      check_outputs("reset");
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rstn = 1'b0;
      req  = 4'b0000;
      done = 1'b0;
      model_reset();
      #12;
      check_outputs("por");
      @(negedge clk);
      rstn = 1'b1;

      // Single requester: hold limit, timeout, gap, re-grant.
      repeat (12) cycle("solo", 4'b0001, 1'b0);

      // All requesting, done on the 2nd grant cycle: order 0,1,2,3,0.
      apply_reset();
      prev_g = 4'b0000;
      order_q.delete();
      repeat (16) begin
         cycle("rr", 4'b1111, 1'((m_owner >= 0) && (m_held == 2)));
         if (grant != 4'b0000 && grant != prev_g) order_q.push_back(grant);
         prev_g = grant;
      end
      check("rr.count", 32'(order_q.size() >= 5), 32'd1);
      if (order_q.size() >= 5) begin
         check("rr.o0", 32'(order_q[0]), 32'h1);
         check("rr.o1", 32'(order_q[1]), 32'h2);
         check("rr.o2", 32'(order_q[2]), 32'h4);
         check("rr.o3", 32'(order_q[3]), 32'h8);
         check("rr.o4", 32'(order_q[4]), 32'h1);
      end

      // Owner 2 drops its request while requester 0 waits.
      apply_reset();
      cycle("drop", 4'b0100, 1'b0);
      cycle("drop", 4'b0100, 1'b0);
      cycle("drop", 4'b0001, 1'b0);
      check("drop.gap_state", 32'(state), 32'h2);
      check("drop.gap_to",    32'(timeout), 32'h0);
      cycle("drop", 4'b0001, 1'b0);
      check("drop.next_grant", 32'(grant), 32'h1);
      check("drop.next_state", 32'(state), 32'h4);

      // done coinciding with the last allowed cycle wins over the hold limit.
      apply_reset();
      repeat (4) cycle("edge", 4'b0010, 1'b0);
      cycle("edge", 4'b0010, 1'b1);
      check("edge.to",    32'(timeout), 32'h0);
      check("edge.state", 32'(state), 32'h2);

      // Asynchronous reset in the middle of a grant.
      apply_reset();
      cycle("arst", 4'b0100, 1'b0);
      cycle("arst", 4'b0100, 1'b0);
      @(posedge clk);
      #2;
      rstn = 1'b0;
      #1;
      check("arst.grant", 32'(grant), 32'h0);
      check("arst.state", 32'(state), 32'h0);
      check("arst.busy",  32'(busy),  32'h0);
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
      cycle("arst", 4'b1000, 1'b0);
      check("arst.first", 32'(grant), 32'h8);

      // No requests: done pulses are ignored.
      apply_reset();
      repeat (10) cycle("idle", 4'b0000, 1'($urandom_range(0, 1)));

      // Random traffic with sticky requests so the hold limit is reached regularly.
      apply_reset();
      r_rand = 4'b0000;
      repeat (600) begin
         if ($urandom_range(0, 9) < 3) r_rand = 4'($urandom);
         d_rand = 1'($urandom_range(0, 5) == 0);
         cycle("rand", r_rand, d_rand);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
